// File: rtl/cell2_tester.sv
// cell2_tester: walks {A,B} = 00,01,10,11 into a 2-input cell for PASSES sweeps,
//   samples the synchronized cell output after a settle window and counts mismatches vs TRUTH.
// Latency: done rises 4*PASSES*(SETTLE+1) cycles after the edge that accepts start.
// Backpressure: none; start is accepted only in IDLE/DONE and is ignored while busy.
// Optional build macro: CELL2_TESTER_STABLE_CHECK_EN also fails a sample whose
//   synchronized value differs from the previous cycle's value.
// Ports: clk, rst (async active-high); start run request; dut_y raw cell output;
//   stim_a/stim_b registered cell drive; busy/done/pass run status;
//   err_cnt saturating mismatch count; fail_valid/fail_vec per-mismatch pulse and last failing vector.
module cell2_tester #(
  parameter logic [3:0] TRUTH  = 4'b0111,
  parameter int unsigned SETTLE = 4,
  parameter int unsigned PASSES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_y,
  output logic       stim_a,
  output logic       stim_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic       fail_valid,
  output logic [1:0] fail_vec
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [3:0] PASS_LAST   = 4'(PASSES - 1);

  logic [1:0] state;
  logic [1:0] vec;
  logic [3:0] pass_cnt;
  logic [3:0] settle_cnt;
  logic       y_m;
  logic       y_s;
  logic       mismatch;
  logic [1:0] vec_next;

  assign vec_next = vec + 2'd1;
  assign pass     = done && (err_cnt == 8'd0);

`ifdef CELL2_TESTER_STABLE_CHECK_EN
  // Previous-cycle copy of y_s; a change right before sampling means the cell
  // output had not settled, which is reported as a single mismatch.
  logic y_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) y_prev <= 1'b0;
    else     y_prev <= y_s;
  end

  assign mismatch = (y_s != TRUTH[vec]) || (y_s != y_prev);
`else
  assign mismatch = (y_s != TRUTH[vec]);
`endif

  // dut_y is asynchronous to clk; only y_s is ever looked at.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_m <= 1'b0;
      y_s <= 1'b0;
    end else begin
      y_m <= dut_y;
      y_s <= y_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      vec        <= 2'd0;
      pass_cnt   <= 4'd0;
      settle_cnt <= 4'd0;
      stim_a     <= 1'b0;
      stim_b     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_cnt    <= 8'd0;
      fail_valid <= 1'b0;
      fail_vec   <= 2'd0;
    end else begin
      fail_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_HOLD;
            vec        <= 2'd0;
            pass_cnt   <= 4'd0;
            settle_cnt <= 4'd0;
            stim_a     <= 1'b0;
            stim_b     <= 1'b0;
            err_cnt    <= 8'd0;
            done       <= 1'b0;
            busy       <= 1'b1;
          end
        end
        ST_HOLD: begin
          // SETTLE hold cycles, then the sample cycle makes SETTLE+1 per vector.
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= 4'd0;
            state      <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            fail_vec   <= vec;
            fail_valid <= 1'b1;
          end
          vec <= vec_next;
          if (vec == 2'd3 && pass_cnt == PASS_LAST) begin
            state  <= ST_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            stim_a <= 1'b0;
            stim_b <= 1'b0;
          end else begin
            if (vec == 2'd3) pass_cnt <= pass_cnt + 4'd1;
            state  <= ST_HOLD;
            stim_a <= vec_next[1];
            stim_b <= vec_next[0];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell2_tester.sv
module tb_cell2_tester;

  logic clk = 1'b0;
  logic rst;
  logic start, start15;
  logic go, go15;
  logic dut_y, y15;

  logic       stim_a, stim_b, busy, done, pass, fail_valid;
  logic [7:0] err_cnt;
  logic [1:0] fail_vec;
  logic       stim_a15, stim_b15, busy15, done15, pass15, fail_valid15;
  logic [7:0] err_cnt15;
  logic [1:0] fail_vec15;

  always #5 clk = ~clk;

  cell2_tester dut (
    .clk(clk), .rst(rst), .start(start), .dut_y(dut_y),
    .stim_a(stim_a), .stim_b(stim_b), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_valid(fail_valid), .fail_vec(fail_vec)
  );

  cell2_tester #(.PASSES(15)) dut15 (
    .clk(clk), .rst(rst), .start(start15), .dut_y(y15),
    .stim_a(stim_a15), .stim_b(stim_b15), .busy(busy15), .done(done15), .pass(pass15),
    .err_cnt(err_cnt15), .fail_valid(fail_valid15), .fail_vec(fail_vec15)
  );

  assign y15 = 1'b0;  // stuck-at-0 cell for the long-run instance

  // Cell model: 0 ideal NAND, 1 stuck-at-1, 2 AND, 4 NAND with a pre-sample glitch.
  int   mode = 0;
  logic cell_q = 1'b1;
  int   rel = 0, rel15 = 0;
  logic run_act = 1'b0;
  logic glitch;

  always @(posedge clk) begin
    case (mode)
      1:       cell_q <= 1'b1;
      2:       cell_q <= stim_a & stim_b;
      default: cell_q <= ~(stim_a & stim_b);
    endcase
  end

  // Inverting dut_y in cycle 5k+1 makes y_s differ only in the cycle before
  // the sample of vector k; k=1 and k=5 are vector 01 in each sweep.
  always_comb begin
    glitch = 1'b0;
    if (mode == 4 && run_act && (rel == 6 || rel == 26)) glitch = 1'b1;
  end
  assign dut_y = cell_q ^ glitch;

  // Cycle counters relative to the edge that accepts start (go marks it).
  always @(posedge clk) begin
    if (go) begin
      rel     <= 0;
      run_act <= 1'b1;
    end else begin
      rel <= rel + 1;
      if (rst || rel >= 39) run_act <= 1'b0;
    end
    if (go15) rel15 <= 0;
    else      rel15 <= rel15 + 1;
  end

  // Scoreboard
  typedef struct {
    int err;
    int pas;
    int vec;
    int cyc;
  } res_t;

  res_t res_q[$];
  res_t res15_q[$];
  int   fv_q[$];
  res_t r, r15;
  int   exp_fv;
  int   n_cmp = 0, n_bad = 0;
  int   pulses15 = 0;
  int   tmo_cnt;
  logic done_d = 1'b0, done15_d = 1'b0;
  logic chk_idle, end_req;
  logic end_done = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_idle) begin
      check("reset_outputs", longint'({stim_a, stim_b, busy, done, pass, err_cnt, fail_valid, fail_vec}), 0);
      check("reset_outputs15", longint'({stim_a15, stim_b15, busy15, done15, pass15, err_cnt15, fail_valid15, fail_vec15}), 0);
    end
    // Sample cycles: expected {stim_a,stim_b,busy,done,pass} = {v,1,0,0}.
    if (run_act && !rst && rel < 40 && rel % 5 == 4)
      check("stim_vec", longint'({stim_a, stim_b, busy, done, pass}), ((rel / 5) % 4) * 8 + 4);
    if (fail_valid) begin
      exp_fv = (fv_q.size() != 0) ? fv_q.pop_front() : 4;
      check("fail_pulse_vec", fail_vec, exp_fv);
    end
    if (done && !done_d) begin
      if (res_q.size() != 0) r = res_q.pop_front();
      else r = '{err: -1, pas: -1, vec: -1, cyc: -1};
      check("done_cycle", rel, r.cyc);
      check("err_cnt", err_cnt, r.err);
      check("pass", pass, r.pas);
      check("fail_vec", fail_vec, r.vec);
      check("done_idle_stim", longint'({stim_a, stim_b, busy}), 0);
    end
    done_d = done;

    if (fail_valid15) pulses15++;
    if (done15 && !done15_d) begin
      if (res15_q.size() != 0) r15 = res15_q.pop_front();
      else r15 = '{err: -1, pas: -1, vec: -1, cyc: -1};
      check("done_cycle15", rel15, r15.cyc);
      check("err_cnt15", err_cnt15, r15.err);
      check("pass15", pass15, r15.pas);
      check("fail_vec15", fail_vec15, r15.vec);
      check("fail_pulses15", pulses15, 45);
      pulses15 = 0;
    end
    done15_d = done15;

    if (end_req && !end_done) begin
      check("fail_queue_left", fv_q.size(), 0);
      check("result_queue_left", res_q.size(), 0);
      check("result15_queue_left", res15_q.size(), 0);
      check("done_timeouts", tmo_cnt, 0);
      end_done = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    step();
    start = 1'b1;
    go    = 1'b1;
    step();
    start = 1'b0;
    go    = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (!done && k < bound) begin
      step();
      k++;
    end
    if (!done) tmo_cnt++;
  endtask

  task automatic run15();
    step();
    start15 = 1'b1;
    go15    = 1'b1;
    step();
    start15 = 1'b0;
    go15    = 1'b0;
  endtask

  task automatic wait_done15(input int bound);
    int k = 0;
    while (!done15 && k < bound) begin
      step();
      k++;
    end
    if (!done15) tmo_cnt++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; start15 = 1'b0; go = 1'b0; go15 = 1'b0;
    chk_idle = 1'b0; end_req = 1'b0; tmo_cnt = 0;
    repeat (3) step();
    rst = 1'b0;
    step(); chk_idle = 1'b1;
    step(); chk_idle = 1'b0;

    // Ideal NAND: clean 2-sweep run, no fail pulses.
    mode = 0;
    res_q.push_back('{err: 0, pas: 1, vec: 0, cyc: 40});
    pulse_start(); wait_done(100);

    // Stuck-at-1: only vector 11 fails, once per sweep.
    mode = 1;
    fv_q.push_back(3); fv_q.push_back(3);
    res_q.push_back('{err: 2, pas: 0, vec: 3, cyc: 40});
    pulse_start(); wait_done(100);

    // AND instead of NAND: every sample fails.
    mode = 2;
    for (int s = 0; s < 2; s++)
      for (int v = 0; v < 4; v++) fv_q.push_back(v);
    res_q.push_back('{err: 8, pas: 0, vec: 3, cyc: 40});
    pulse_start(); wait_done(100);

    // start re-pulsed mid-run is ignored, then reset aborts the run.
    mode = 0;
    pulse_start();
    repeat (9) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step(); chk_idle = 1'b1;
    step(); chk_idle = 1'b0;
    res_q.push_back('{err: 0, pas: 1, vec: 0, cyc: 40});
    pulse_start(); wait_done(100);

    // NAND with a one-cycle wobble just before the vector-01 sample.
    mode = 4;
`ifdef CELL2_TESTER_STABLE_CHECK_EN
    fv_q.push_back(1); fv_q.push_back(1);
    res_q.push_back('{err: 2, pas: 0, vec: 1, cyc: 40});
`else
    res_q.push_back('{err: 0, pas: 1, vec: 0, cyc: 40});
`endif
    pulse_start(); wait_done(100);
    mode = 0;

    // PASSES=15, stuck-at-0: 3 failing vectors x 15 sweeps, cleared per run.
    for (int n = 0; n < 5; n++) begin
      res15_q.push_back('{err: 45, pas: 0, vec: 2, cyc: 300});
      run15(); wait_done15(400);
    end

    // Counter preset near the top must saturate at 255.
    res15_q.push_back('{err: 255, pas: 0, vec: 2, cyc: 300});
    run15();
    repeat (99) step();
    force dut15.err_cnt = 8'd254;
    release dut15.err_cnt;
    wait_done15(400);

    end_req = 1'b1;
    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
